// File: rtl/cu_sequencer.sv
// cu_sequencer: multi-cycle control-unit sequencer.
// Walks each instruction through FETCH/DECODE and its class-specific states.
// Pulses retire and counts every completed instruction.
// Latches into a sticky TRAP on an unsupported opcode.
module cu_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  input  logic             stall,
  output logic [3:0]       curr_state,
  output logic             retire,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             illegal_op
);

  localparam logic [3:0] S_FETCH     = 4'b0000;
  localparam logic [3:0] S_DECODE    = 4'b0001;
  localparam logic [3:0] S_MEM_ADR   = 4'b0010;
  localparam logic [3:0] S_MEM_READ  = 4'b0011;
  localparam logic [3:0] S_MEM_WB    = 4'b0100;
  localparam logic [3:0] S_MEM_WRITE = 4'b0101;
  localparam logic [3:0] S_EXECUTE_R = 4'b0110;
  localparam logic [3:0] S_ALU_WB    = 4'b0111;
  localparam logic [3:0] S_EXECUTE_I = 4'b1000;
  localparam logic [3:0] S_BNEZ      = 4'b1001;
  localparam logic [3:0] S_TRAP      = 4'b1010;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]       state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic             retire_q, retire_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             complete;

  // Next-state, opcode latch, retire and counter logic; stall freezes everything.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    retire_d  = 1'b0;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    complete  = 1'b0;
    if (!stall) begin
      case (state_q)
        S_FETCH:     if (mem_ready) state_d = S_DECODE;
        S_DECODE: begin
          op_d = opcode;
          case (opcode)
            OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
            OP_RTYPE:          state_d = S_EXECUTE_R;
            OP_ITYPE:          state_d = S_EXECUTE_I;
            OP_BRANCH:         state_d = S_BNEZ;
            default: begin
              state_d   = S_TRAP;
              illegal_d = 1'b1;
            end
          endcase
        end
        // Memory path follows the opcode captured in DECODE, not the live input.
        S_MEM_ADR: begin
          if (op_q == OP_LOAD)       state_d = S_MEM_READ;
          else if (op_q == OP_STORE) state_d = S_MEM_WRITE;
          else                       state_d = S_FETCH;
        end
        S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
        S_MEM_WB: begin
          state_d  = S_FETCH;
          complete = 1'b1;
        end
        S_MEM_WRITE: begin
          if (mem_ready) begin
            state_d  = S_FETCH;
            complete = 1'b1;
          end
        end
        S_EXECUTE_R: state_d = S_ALU_WB;
        S_EXECUTE_I: state_d = S_ALU_WB;
        S_ALU_WB, S_BNEZ: begin
          state_d  = S_FETCH;
          complete = 1'b1;
        end
        S_TRAP:      state_d = S_TRAP;
        // Unused encodings recover to FETCH without retiring anything.
        default:     state_d = S_FETCH;
      endcase
    end
    if (complete) begin
      retire_d = 1'b1;
      cnt_d    = cnt_q + CNT_ONE;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= 7'b0;
      retire_q  <= 1'b0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retire_q  <= retire_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  assign curr_state  = state_q;
  assign retire      = retire_q;
  assign retired_cnt = cnt_q;
  assign illegal_op  = illegal_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// tb_cu_sequencer: directed scenarios plus randomized traffic against a
// route-list reference model of the sequencer.
module tb_cu_sequencer;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [6:0]    opcode = 7'h0;
  logic          mem_ready = 1'b0;
  logic          stall = 1'b0;
  logic [3:0]    curr_state;
  logic          retire;
  logic [CW-1:0] retired_cnt;
  logic          illegal_op;

  cu_sequencer #(.CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .stall       (stall),
    .curr_state  (curr_state),
    .retire      (retire),
    .retired_cnt (retired_cnt),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: current state code plus the remaining route of the
  // instruction in flight, chosen once when the opcode is decoded.
  int m_state = 0;
  int m_path[$];
  bit m_ret = 0;
  int m_cnt = 0;
  bit m_ill = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit go;
    m_ret = 0;
    if (rst) begin
      m_state = 0;
      m_path.delete();
      m_cnt = 0;
      m_ill = 0;
    end else if (!stall && m_state != 10) begin
      go = (m_state == 0 || m_state == 3 || m_state == 5) ? mem_ready : 1'b1;
      if (go) begin
        if (m_state == 0) begin
          m_state = 1;
        end else if (m_state == 1) begin
          case (opcode)
            7'h03:   m_path = '{2, 3, 4};
            7'h23:   m_path = '{2, 5};
            7'h33:   m_path = '{6, 7};
            7'h13:   m_path = '{8, 7};
            7'h63:   m_path = '{9};
            default: m_path.delete();
          endcase
          if (m_path.size() == 0) begin
            m_state = 10;
            m_ill = 1;
          end else begin
            m_state = m_path.pop_front();
          end
        end else if (m_path.size() > 0) begin
          m_state = m_path.pop_front();
        end else begin
          m_state = 0;
          m_ret = 1;
          m_cnt = (m_cnt + 1) % (1 << CW);
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit s, input bit mr, input logic [6:0] op);
    rst = r;
    stall = s;
    mem_ready = mr;
    opcode = op;
    @(posedge clk);
    model_edge();
    #1;
    chk("state", {28'h0, curr_state}, m_state);
    chk("retire", {31'h0, retire}, {31'h0, m_ret});
    chk("count", {28'h0, retired_cnt}, m_cnt);
    chk("illegal", {31'h0, illegal_op}, {31'h0, m_ill});
  endtask

  initial begin
    int seq[];
    int rets;
    logic [6:0] ops[5];
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63};

    // Reset state
    step(1, 0, 1, 7'h03);
    chk("rst_state", {28'h0, curr_state}, 0);
    chk("rst_cnt", {28'h0, retired_cnt}, 0);

    // Load: 0,1,2,3,4,0 with one retire
    seq = '{1, 2, 3, 4, 0};
    rets = 0;
    foreach (seq[i]) begin
      step(0, 0, 1, 7'h03);
      chk("load_seq", {28'h0, curr_state}, seq[i]);
      rets += retire;
    end
    chk("load_cnt", {28'h0, retired_cnt}, 1);
    chk("load_ret", rets, 1);

    // Store with memory wait in MEM_WRITE
    step(1, 0, 1, 7'h23);
    step(0, 0, 1, 7'h23);
    step(0, 0, 1, 7'h23);
    step(0, 0, 0, 7'h23);
    chk("st_wr", {28'h0, curr_state}, 5);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 7'h23);
      chk("st_hold", {28'h0, curr_state}, 5);
    end
    step(0, 0, 1, 7'h23);
    chk("st_done", {28'h0, curr_state}, 0);
    chk("st_cnt", {28'h0, retired_cnt}, 1);

    // Illegal opcode traps until reset
    step(1, 0, 1, 7'h00);
    step(0, 0, 1, 7'h7f);
    step(0, 0, 1, 7'h7f);
    chk("trap_ill", {31'h0, illegal_op}, 1);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, i[0], 7'h03);
      chk("trap_hold", {28'h0, curr_state}, 10);
    end
    step(1, 0, 1, 7'h03);
    chk("trap_rst", {28'h0, curr_state}, 0);
    chk("trap_rst_ill", {31'h0, illegal_op}, 0);

    // Stall in EXECUTE_R
    step(0, 0, 1, 7'h33);
    step(0, 0, 1, 7'h33);
    chk("exr", {28'h0, curr_state}, 6);
    step(0, 1, 1, 7'h33);
    step(0, 1, 1, 7'h33);
    chk("stall_hold", {28'h0, curr_state}, 6);
    step(0, 0, 1, 7'h33);
    chk("alu_wb", {28'h0, curr_state}, 7);
    step(0, 0, 1, 7'h33);
    chk("r_done", {28'h0, curr_state}, 0);
    chk("r_ret", {31'h0, retire}, 1);

    // 16 branches wrap the 4-bit counter
    step(1, 0, 1, 7'h63);
    rets = 0;
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 3; k++) begin
        step(0, 0, 1, 7'h63);
        rets += retire;
      end
      if (i == 14) chk("br_15", {28'h0, retired_cnt}, 15);
    end
    chk("br_wrap", {28'h0, retired_cnt}, 0);
    chk("br_rets", rets, 16);

    // Reset mid-load aborts without retiring
    step(1, 0, 1, 7'h03);
    step(0, 0, 1, 7'h03);
    step(0, 0, 1, 7'h03);
    step(0, 0, 1, 7'h03);
    step(0, 0, 0, 7'h33);
    chk("ab_rd", {28'h0, curr_state}, 3);
    step(1, 0, 1, 7'h33);
    chk("ab_state", {28'h0, curr_state}, 0);
    chk("ab_cnt", {28'h0, retired_cnt}, 0);
    chk("ab_ret", {31'h0, retire}, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit r, s, mr;
      logic [6:0] op;
      int pick;
      r  = (m_state == 10) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 59) == 0);
      s  = ($urandom_range(0, 4) == 0);
      mr = ($urandom_range(0, 2) != 0);
      pick = $urandom_range(0, 9);
      op = (pick < 5) ? ops[pick] : ((pick == 9) ? 7'($urandom) : ops[pick - 5]);
      step(r, s, mr, op);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/cu_sequencer.md
CU_SEQUENCER -- requirements
Module: cu_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port opcode  input  7  instr[6:0] from the instruction register; valid in DECODE.
REQ-005 SHALL have port mem_ready  input  1  unified memory has completed the current access this cycle.
REQ-006 SHALL have port stall  input  1  freeze request from the debug/hazard logic.
REQ-007 SHALL have port curr_state  output  4  current state code, fed to the main decoder.
REQ-008 SHALL have port retire  output  1  one-cycle pulse when an instruction completes.
REQ-009 SHALL have port retired_cnt  output  CNT_W  count of completed instructions.
REQ-010 SHALL have port illegal_op  output  1  sticky flag; an unsupported opcode was decoded.

Function
REQ-011 SHALL use state codes: FETCH 0000, DECODE 0001, MEM_ADR 0010, MEM_READ 0011, MEM_WB 0100, MEM_WRITE 0101, EXECUTE_R 0110, ALU_WB 0111, EXECUTE_I 1000, BNEZ 1001, TRAP 1010.
REQ-012 SHALL drive curr_state directly from the state register: registered, no combinational path from any input.
REQ-013 SHALL decode opcodes: 0000011 load, 0100011 store, 0110011 R-type, 0010011 I-type ALU, 1100011 branch; any other value is illegal.
REQ-014 SHALL, in DECODE, latch opcode into an internal register op_q; MEM_ADR uses op_q, not the live opcode input.
REQ-015 SHALL transition: FETCH -> DECODE if mem_ready, else hold FETCH.
REQ-016 SHALL transition from DECODE: load/store -> MEM_ADR; R-type -> EXECUTE_R; I-type -> EXECUTE_I; branch -> BNEZ; illegal -> TRAP.
REQ-017 SHALL transition from MEM_ADR: op_q load -> MEM_READ; op_q store -> MEM_WRITE.
REQ-018 SHALL transition: MEM_READ -> MEM_WB if mem_ready, else hold.
REQ-019 SHALL transition: MEM_WRITE -> FETCH if mem_ready, else hold.
REQ-020 SHALL transition unconditionally: MEM_WB -> FETCH; EXECUTE_R -> ALU_WB; EXECUTE_I -> ALU_WB; ALU_WB -> FETCH; BNEZ -> FETCH.
REQ-021 SHALL hold TRAP indefinitely; only rst leaves TRAP.
REQ-022 SHALL set illegal_op on the DECODE -> TRAP edge; it stays 1 until rst.
REQ-023 SHALL treat any unused state code (1011-1111) as FETCH on the next edge, with no retire.
REQ-024 SHALL, while stall=1, hold state, op_q, retired_cnt; retire=0; mem_ready ignored that cycle.
REQ-025 SHALL give stall priority over mem_ready when both are high.
REQ-026 SHALL assert retire, registered, for exactly the cycle after a completing transition: MEM_WB -> FETCH, MEM_WRITE -> FETCH, ALU_WB -> FETCH, BNEZ -> FETCH.
REQ-027 SHALL increment retired_cnt by 1 on every completing transition, in the same edge that sets retire; it wraps from all-ones to 0.
REQ-028 SHALL fix instruction latencies, measured from FETCH entry with mem_ready=1 and stall=0: load 5, store 4, R-type 4, I-type 4, branch 3 cycles.

Reset
REQ-029 SHALL, on any clk edge with rst=1, set state FETCH, op_q 0, retire 0, retired_cnt 0, illegal_op 0, regardless of stall or state.
REQ-030 SHALL, after rst is released, begin in FETCH on that cycle; a reset mid-instruction aborts it with no retire and no count.

Verification
REQ-031 SHALL cover: rst 1 cycle, mem_ready=1, opcode 0000011 -> states 0,1,2,3,4,0; retire pulses once; retired_cnt=1.
REQ-032 SHALL cover: store 0100011, mem_ready low 3 cycles in MEM_WRITE -> state 0101 held 4 cycles, then 0000; retired_cnt increments once.
REQ-033 SHALL cover: opcode 1111111 at DECODE -> state 1010, illegal_op=1, held 20 cycles with mem_ready toggling; rst -> 0000, illegal_op=0.
REQ-034 SHALL cover: stall=1 for 2 cycles in EXECUTE_R with mem_ready=1 -> 0110 held 3 cycles, then 0111, 0000.
REQ-035 SHALL cover: CNT_W=4, 16 back-to-back branches 1100011 -> retired_cnt wraps 15 -> 0; retire pulses 16 times.
REQ-036 SHALL cover: rst asserted in MEM_READ after opcode changes to 0110011 mid-load -> next state 0000, retired_cnt unchanged at 0, no retire.
